// File: rtl/pux_feed_if.sv
// Stream bundle between pux_feed (master) and the pux stream interface (slave):
// opcode, three operand channels and the returning status word.
interface pux_feed_if #(
   parameter int OPCW  = 8,
   parameter int DATAW = 16
);
   logic [OPCW-1:0]  axis_opcode_data;
   logic             axis_opcode_valid;
   logic             axis_opcode_ready;
   logic [DATAW-1:0] axis_abuff_data;
   logic             axis_abuff_valid;
   logic             axis_abuff_ready;
   logic [DATAW-1:0] axis_bbuff_data;
   logic             axis_bbuff_valid;
   logic             axis_bbuff_ready;
   logic [DATAW-1:0] axis_mbuff_data;
   logic             axis_mbuff_valid;
   logic             axis_mbuff_ready;
   logic [DATAW-1:0] axis_status_data;
   logic             axis_status_valid;
   logic             axis_status_ready;

   modport master (
      output axis_opcode_data, axis_opcode_valid, input axis_opcode_ready,
      output axis_abuff_data, axis_abuff_valid, input axis_abuff_ready,
      output axis_bbuff_data, axis_bbuff_valid, input axis_bbuff_ready,
      output axis_mbuff_data, axis_mbuff_valid, input axis_mbuff_ready,
      input axis_status_data, axis_status_valid, output axis_status_ready
   );

   modport slave (
      input axis_opcode_data, axis_opcode_valid, output axis_opcode_ready,
      input axis_abuff_data, axis_abuff_valid, output axis_abuff_ready,
      input axis_bbuff_data, axis_bbuff_valid, output axis_bbuff_ready,
      input axis_mbuff_data, axis_mbuff_valid, output axis_mbuff_ready,
      output axis_status_data, axis_status_valid, input axis_status_ready
   );
endinterface

// File: rtl/pux_feed.sv
// Initiator-side feeder for the pux stream interface: opcode, A/B/M operand streams, status.
// Optional status-wait timeout enabled by defining PUX_FEED_TIMEOUT_EN.

// One operand channel: local buffer plus its own registered AXIS source.
module pux_feed_lane #(
   parameter int DATAW = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [DATAW-1:0] wr_data,
   input  logic             clr,
   input  logic             launch,
   input  logic [AW:0]      len,
   input  logic             ready,
   output logic             valid,
   output logic [DATAW-1:0] data,
   output logic             cmpl
);
   localparam logic [AW-1:0] ADDR0 = '0;

   logic [DATAW-1:0] mem [DEPTH];
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_nxt;

   assign cnt_nxt = cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // data is prefetched into an output register so it only moves on a handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         cnt   <= '0;
         cmpl  <= 1'b0;
      end else if (clr) begin
         valid <= 1'b0;
         cnt   <= '0;
         cmpl  <= 1'b0;
      end else if (launch) begin
         valid <= 1'b1;
         data  <= mem[ADDR0];
      end else if (valid && ready) begin
         if (cnt_nxt == len) begin
            valid <= 1'b0;
            cmpl  <= 1'b1;
         end else begin
            cnt  <= cnt_nxt;
            data <= mem[cnt_nxt[AW-1:0]];
         end
      end
   end
endmodule

module pux_feed #(
   parameter int OPCW    = 8,
   parameter int DATAW   = 16,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr_en,
   input  logic [1:0]       cfg_wr_sel,
   input  logic [AW-1:0]    cfg_wr_addr,
   input  logic [DATAW-1:0] cfg_wr_data,
   input  logic [AW:0]      cfg_len,
   input  logic             stream_reqest,
   pux_feed_if.master       axis,
   output logic             busy,
   output logic             done,
   output logic [DATAW-1:0] status_q,
   output logic             timeout_err
);
   localparam int NUM_LANES = 3;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW != $clog2(DEPTH) || TIMEOUT < 1)
   begin : g_bad_cfg
      $error("pux_feed: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, OPC, DATA, STAT} state_t;

   state_t                        state_q, state_d;
   logic [AW:0]                   len_q;
   logic [OPCW-1:0]               opc_q;
   logic                          opc_valid, stat_ready;
   logic                          wr_ok, start, opc_hs, launch, stat_hs, tmo;
   logic [NUM_LANES-1:0]          ln_valid, ln_ready, ln_cmpl;
   logic [NUM_LANES-1:0][DATAW-1:0] ln_data;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start)    state_d = OPC;
         OPC:  if (opc_hs)   state_d = (len_q == '0) ? STAT : DATA;
         DATA: if (&ln_cmpl) state_d = STAT;
         STAT: if (stat_hs || tmo) state_d = IDLE;
         default:            state_d = IDLE;
      endcase
   end

   // done is high in the first IDLE cycle, which blocks a back-to-back start
   always_comb begin
      busy    = (state_q != IDLE);
      wr_ok   = cfg_wr_en && (state_q == IDLE);
      start   = (state_q == IDLE) && stream_reqest && !done;
      opc_hs  = opc_valid && axis.axis_opcode_ready;
      launch  = opc_hs && (len_q != '0);
      stat_hs = stat_ready && axis.axis_status_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opc_q      <= '0;
         len_q      <= '0;
         opc_valid  <= 1'b0;
         stat_ready <= 1'b0;
         done       <= 1'b0;
         status_q   <= '0;
      end else begin
         opc_valid  <= (state_d == OPC);
         stat_ready <= (state_d == STAT);
         done       <= (state_q == STAT) && (state_d == IDLE);
         if (wr_ok && cfg_wr_sel == 2'd3) opc_q <= cfg_wr_data[OPCW-1:0];
         if (start) len_q <= (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
         if (stat_hs)  status_q <= axis.axis_status_data;
         else if (tmo) status_q <= '1;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      pux_feed_lane #(.DATAW(DATAW), .DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_ok && (cfg_wr_sel == 2'(i))),
         .wr_addr (cfg_wr_addr),
         .wr_data (cfg_wr_data),
         .clr     (start),
         .launch  (launch),
         .len     (len_q),
         .ready   (ln_ready[i]),
         .valid   (ln_valid[i]),
         .data    (ln_data[i]),
         .cmpl    (ln_cmpl[i])
      );
   end

   assign ln_ready = {axis.axis_mbuff_ready, axis.axis_bbuff_ready, axis.axis_abuff_ready};
   assign axis.axis_opcode_data  = opc_q;
   assign axis.axis_opcode_valid = opc_valid;
   assign axis.axis_abuff_data   = ln_data[0];
   assign axis.axis_abuff_valid  = ln_valid[0];
   assign axis.axis_bbuff_data   = ln_data[1];
   assign axis.axis_bbuff_valid  = ln_valid[1];
   assign axis.axis_mbuff_data   = ln_data[2];
   assign axis.axis_mbuff_valid  = ln_valid[2];
   assign axis.axis_status_ready = stat_ready;

`ifdef PUX_FEED_TIMEOUT_EN
   logic [15:0] tcnt;
   logic        terr;

   assign tmo         = (state_q == STAT) && !stat_hs && (tcnt == 16'(TIMEOUT - 1));
   assign timeout_err = terr;

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt <= '0;
         terr <= 1'b0;
      end else begin
         tcnt <= (state_q == STAT) ? tcnt + 1'b1 : '0;
         if (tmo) terr <= 1'b1;
      end
   end
`else
   assign tmo         = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_pux_feed.sv
// Directed bench for pux_feed: a scoreboard of expected opcode/A/B/M beats is filled
// when a transaction is launched and drained by a negedge monitor.
module tb_pux_feed;
   logic        clk, rst;
   logic        cfg_wr_en;
   logic [1:0]  cfg_wr_sel;
   logic [2:0]  cfg_wr_addr;
   logic [15:0] cfg_wr_data;
   logic [3:0]  cfg_len;
   logic        stream_reqest;
   logic        busy, done, timeout_err;
   logic [15:0] status_q;

   pux_feed_if #(.OPCW(8), .DATAW(16)) pif ();

   pux_feed #(.OPCW(8), .DATAW(16), .DEPTH(8), .AW(3), .TIMEOUT(20)) dut (
      .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
      .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_len(cfg_len),
      .stream_reqest(stream_reqest), .axis(pif.master), .busy(busy), .done(done),
      .status_q(status_q), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   logic [15:0] q [4][$];
   logic [15:0] ma [8], mb [8], mm [8];
   logic [7:0]  opc_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: every presented beat must match the scoreboard head; valid may not drop unserved.
   initial begin
      logic [3:0] v, r, pv, phs;
      logic [3:0][15:0] d;
      logic psr;
      pv = '0; phs = '0; psr = 1'b0;
      forever begin
         @(negedge clk);
         v = {pif.axis_mbuff_valid, pif.axis_bbuff_valid, pif.axis_abuff_valid, pif.axis_opcode_valid};
         r = {pif.axis_mbuff_ready, pif.axis_bbuff_ready, pif.axis_abuff_ready, pif.axis_opcode_ready};
         d[0] = {8'h00, pif.axis_opcode_data};
         d[1] = pif.axis_abuff_data;
         d[2] = pif.axis_bbuff_data;
         d[3] = pif.axis_mbuff_data;
         if (rst) begin
            pv = '0; phs = '0; psr = 1'b0;
         end else begin
            for (int ch = 0; ch < 4; ch++) begin
               if (pv[ch] && !phs[ch]) chk($sformatf("valid_hold_ch%0d", ch), 32'(v[ch]), 32'd1);
               if (v[ch]) begin
                  if (q[ch].size() == 0) chk($sformatf("extra_beat_ch%0d", ch), 32'(v[ch]), 32'd0);
                  else begin
                     chk($sformatf("beat_ch%0d", ch), 32'(d[ch]), 32'(q[ch][0]));
                     if (r[ch]) void'(q[ch].pop_front());
                  end
               end
            end
            pv = v; phs = v & r;
            if (pif.axis_status_ready && !psr)
               chk("stat_after_data", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
            psr = pif.axis_status_ready;
         end
      end
   end

   task automatic wr(input logic [1:0] sel, input logic [2:0] addr, input logic [15:0] data);
      cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_addr = addr; cfg_wr_data = data;
      @(posedge clk); #1;
      cfg_wr_en = 1'b0;
   endtask

   task automatic load();
      for (int i = 0; i < 8; i++) begin
         wr(2'd0, 3'(i), ma[i]);
         wr(2'd1, 3'(i), mb[i]);
         wr(2'd2, 3'(i), mm[i]);
      end
      wr(2'd3, 3'd0, {8'h00, opc_m});
   endtask

   function automatic int qsum();
      return q[0].size() + q[1].size() + q[2].size() + q[3].size();
   endfunction

   // mode 0: all ready; 1: A toggles, B stalled early; 2: as 0 plus a write while busy;
   // 4: status never valid. Entered and left at posedge+1.
   task automatic run_txn(input int mode, input logic [15:0] st,
                          output int busy_cyc, output int stat_cyc, output bit got_done);
      int n;
      n = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
      q[0].push_back({8'h00, opc_m});
      for (int i = 0; i < n; i++) begin
         q[1].push_back(ma[i]);
         q[2].push_back(mb[i]);
         q[3].push_back(mm[i]);
      end
      busy_cyc = 0; stat_cyc = 0; got_done = 1'b0;
      stream_reqest = 1'b1;
      pif.axis_status_data  = st;
      pif.axis_status_valid = (mode != 4);
      for (int k = 0; k < 1500; k++) begin
         pif.axis_opcode_ready = 1'b1;
         pif.axis_abuff_ready  = (mode == 1) ? k[0] : 1'b1;
         pif.axis_bbuff_ready  = (mode == 1) ? (k >= 7) : 1'b1;
         pif.axis_mbuff_ready  = 1'b1;
         if (mode == 2 && k == 3) begin
            cfg_wr_en = 1'b1; cfg_wr_sel = 2'd0; cfg_wr_addr = 3'd0; cfg_wr_data = 16'hFFFF;
         end else cfg_wr_en = 1'b0;
         @(negedge clk);
         if (mode == 1 && k == 10) chk("m_unstalled", q[3].size(), 0);
         if (busy) busy_cyc++;
         if (pif.axis_status_ready) stat_cyc++;
         if (done) begin
            got_done = 1'b1;
            break;
         end
         @(posedge clk); #1;
         stream_reqest = 1'b0;
      end
      @(posedge clk); #1;
      stream_reqest = 1'b0;
      cfg_wr_en = 1'b0;
      pif.axis_status_valid = 1'b1;
   endtask

   initial begin
      int  bc, sc;
      bit  gd;
      for (int i = 0; i < 8; i++) begin
         ma[i] = 16'(i + 1);
         mb[i] = 16'(16'h10 + i);
         mm[i] = 16'(16'h20 + i);
      end
      opc_m = 8'h5A;
      rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_sel = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
      cfg_len = 4'd8; stream_reqest = 1'b0;
      pif.axis_opcode_ready = 1'b1; pif.axis_abuff_ready = 1'b1;
      pif.axis_bbuff_ready = 1'b1; pif.axis_mbuff_ready = 1'b1;
      pif.axis_status_data = '0; pif.axis_status_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {pif.axis_opcode_valid, pif.axis_abuff_valid, pif.axis_bbuff_valid,
                         pif.axis_mbuff_valid, pif.axis_status_ready}, 0);
      chk("rst_busy_done", {busy, done, timeout_err}, 0);
      chk("rst_status_q", status_q, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      load();

      // full throughput, len 8
      run_txn(0, 16'hBEEF, bc, sc, gd);
      chk("t1_done", gd, 1);
      chk("t1_busy_cycles", bc, 11);
      chk("t1_status_q", status_q, 16'hBEEF);
      chk("t1_done_pulse", done, 0);
      chk("t1_drained", qsum(), 0);

      // back-pressure on A and B
      run_txn(1, 16'h1234, bc, sc, gd);
      chk("t2_done", gd, 1);
      chk("t2_status_q", status_q, 16'h1234);
      chk("t2_drained", qsum(), 0);

      // zero-length transaction
      opc_m = 8'h03; wr(2'd3, 3'd0, 16'h0003);
      cfg_len = 4'd0;
      run_txn(0, 16'h0C0C, bc, sc, gd);
      chk("t3_done", gd, 1);
      chk("t3_status_q", status_q, 16'h0C0C);
      chk("t3_drained", qsum(), 0);
      opc_m = 8'h5A; wr(2'd3, 3'd0, 16'h005A);

      // length clamps to DEPTH
      cfg_len = 4'd12;
      run_txn(0, 16'h0012, bc, sc, gd);
      chk("t4_done", gd, 1);
      chk("t4_busy_cycles", bc, 11);
      chk("t4_drained", qsum(), 0);

      // write while busy is dropped; the next pass still streams A[0]=1
      cfg_len = 4'd8;
      run_txn(2, 16'h0A0A, bc, sc, gd);
      chk("t5_done", gd, 1);
      run_txn(0, 16'h0B0B, bc, sc, gd);
      chk("t5_after_done", gd, 1);
      chk("t5_drained", qsum(), 0);

      // reset while DATA is stalled
      q[0].push_back({8'h00, opc_m});
      for (int i = 0; i < 8; i++) begin
         q[1].push_back(ma[i]); q[2].push_back(mb[i]); q[3].push_back(mm[i]);
      end
      pif.axis_abuff_ready = 1'b0; pif.axis_bbuff_ready = 1'b0; pif.axis_mbuff_ready = 1'b0;
      stream_reqest = 1'b1;
      @(posedge clk); #1;
      stream_reqest = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_data_valid", {pif.axis_abuff_valid, pif.axis_bbuff_valid, pif.axis_mbuff_valid}, 3'b111);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_valids_low", {pif.axis_opcode_valid, pif.axis_abuff_valid, pif.axis_bbuff_valid,
                            pif.axis_mbuff_valid, pif.axis_status_ready}, 0);
      chk("t6_busy_low", busy, 0);
      @(posedge clk); #1;
      for (int ch = 0; ch < 4; ch++) q[ch].delete();
      pif.axis_abuff_ready = 1'b1; pif.axis_bbuff_ready = 1'b1; pif.axis_mbuff_ready = 1'b1;

      // opcode register was cleared by reset
      opc_m = 8'h00;
      cfg_len = 4'd0;
      run_txn(0, 16'h0D0D, bc, sc, gd);
      chk("t6_opc_reset_done", gd, 1);
      opc_m = 8'h5A;
      load();
      cfg_len = 4'd8;
      run_txn(0, 16'hCAFE, bc, sc, gd);
      chk("t6_restart_done", gd, 1);
      chk("t6_restart_busy", bc, 11);
      chk("t6_restart_status", status_q, 16'hCAFE);

      // status never arrives
      cfg_len = 4'd2;
      run_txn(4, 16'h5555, bc, sc, gd);
`ifdef PUX_FEED_TIMEOUT_EN
      chk("t7_tmo_done", gd, 1);
      chk("t7_stat_cycles", sc, 20);
      chk("t7_timeout_err", timeout_err, 1);
      chk("t7_status_q", status_q, 16'hFFFF);
`else
      chk("t7_no_done", gd, 0);
      chk("t7_still_stat", {busy, pif.axis_status_ready}, 2'b11);
      chk("t7_long_wait", 32'(sc >= 1000), 1);
      chk("t7_timeout_err", timeout_err, 0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pux_feed.md
Name: pux_feed

Overview:
- Initiator-side driver for the pux stream interface.
- Holds an opcode and three local operand buffers (A, B, M), loaded through a simple write port.
- When the pux stream interface raises stream_reqest, it:
  - sends the opcode on the opcode AXI-Stream channel;
  - sends len words on each of the A/B/M channels, which run in parallel and independently;
  - collects one status word.
- Sits between the host/register bank and the pux stream interface in the crypto datapath.

Parameters:
- OPCW, 8, opcode width.
- DATAW, 16, operand/status word width.
- DEPTH, 8, words per operand buffer; must be a power of 2, at least 2.
- AW, 3, buffer address width; must equal clog2(DEPTH).
- TIMEOUT, 255, status wait limit in cycles. Used only with PUX_FEED_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_wr_en  in  1  buffer/opcode write strobe.
- cfg_wr_sel  in  2  write target: 0=A, 1=B, 2=M, 3=opcode.
- cfg_wr_addr  in  AW  word address; ignored when cfg_wr_sel=3.
- cfg_wr_data  in  DATAW  write data; low OPCW bits are used for the opcode.
- cfg_len  in  AW+1  words per operand channel, 0..DEPTH; sampled at transaction start.
- stream_reqest  in  1  fetch request from the pux stream interface (level).
- axis_opcode_data  out  OPCW  opcode data.
- axis_opcode_valid  out  1  opcode valid.
- axis_opcode_ready  in  1  opcode ready.
- axis_abuff_data/valid  out  DATAW/1  buffer A stream.
- axis_abuff_ready  in  1  buffer A ready.
- axis_bbuff_data/valid  out  DATAW/1  buffer B stream.
- axis_bbuff_ready  in  1  buffer B ready.
- axis_mbuff_data/valid  out  DATAW/1  buffer M stream.
- axis_mbuff_ready  in  1  buffer M ready.
- axis_status_data  in  DATAW  status data.
- axis_status_valid  in  1  status valid.
- axis_status_ready  out  1  status ready.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when the status word is captured.
- status_q  out  DATAW  last captured status.
- timeout_err  out  1  sticky status-timeout flag.

Behaviour:
- Reset values:
  - all valids, axis_status_ready, busy, done, timeout_err = 0;
  - status_q = 0; opcode register = 0;
  - buffer contents undefined.
- Reset mid-transaction: all valids drop on the cycle after rst; no partial state is retained.
- Writes:
  - take effect at the clock edge when cfg_wr_en=1 and the block is IDLE;
  - are silently ignored while busy=1.
- Outputs: all AXIS outputs are registered. Once valid=1, data is held stable until ready=1 on a clock edge. Valid never drops without a handshake.
- State machine:
  - IDLE: busy=0.
    - If stream_reqest=1: latch len=min(cfg_len, DEPTH), clear the channel counters, assert axis_opcode_valid next cycle, go to OPC.
  - OPC: wait for the opcode handshake, then:
    - go to DATA if len!=0;
    - go to STAT if len=0.
    - A/B/M valids rise the cycle after the opcode handshake.
  - DATA: channels A, B, M run concurrently.
    - Each has its own counter 0..len-1 and presents buffer[counter].
    - On handshake the counter increments. At len-1 the valid deasserts and the channel is complete.
    - When all three channels are complete, go to STAT.
    - Back-pressure on one channel never stalls the others.
  - STAT: axis_status_ready=1.
    - On status handshake: capture status_q, pulse done for 1 cycle, deassert ready, return to IDLE.
- Transaction boundaries:
  - A new transaction cannot start in the same cycle that done pulses.
  - Earliest restart is the cycle after return to IDLE.
- stream_reqest is ignored outside IDLE.
- Minimum latency from stream_reqest to the first opcode valid is 1 cycle.
- Full-throughput transaction (all readys high) takes 1 + 1 + len + 1 cycles of busy.

Optional Feature:
- Macro: PUX_FEED_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter counts STAT cycles.
  - If TIMEOUT cycles elapse without the status handshake: set timeout_err (cleared only by rst), set status_q to all-ones, pulse done, return to IDLE.
- Undefined: the counter is absent, STAT waits indefinitely, and timeout_err is tied to 0.

Test Plan:
- Load A={1..8}, B={0x10..0x17}, M={0x20..0x27}, opcode=0x5A; cfg_len=8, all ready=1; pulse stream_reqest; return status 0xBEEF.
  -> Opcode 0x5A, then the three streams in lockstep with the correct words; done pulse; status_q=0xBEEF; busy for 11 cycles.
- Same load; A ready toggles every cycle, B ready held low 5 cycles then high.
  -> All 8 words on each channel in order, data stable while stalled, M completes unaffected, STAT entered only after the last B handshake.
- cfg_len=0, opcode=0x03.
  -> Opcode only, no A/B/M valid, status captured.
- cfg_len=12 with DEPTH=8.
  -> Exactly 8 words per channel.
- cfg_wr_en pulses during DATA writing A[0]=0xFFFF.
  -> Streamed and subsequent A[0] unchanged. rst asserted mid-DATA: all valids 0 next cycle, busy=0, new request works.
- PUX_FEED_TIMEOUT_EN, TIMEOUT=20, status never valid.
  -> done after 20 STAT cycles, timeout_err=1, status_q=0xFFFF. Without the macro: still in STAT after 1000 cycles.
